// File: rtl/act_pkg.sv
// act_pkg: shared constants, sigmoid table and saturating add
// for the shared LUT+interpolation activation unit.
package act_pkg;

  localparam int ACT_DW = 8;
  localparam int ACT_ADDR_W = 4;
  localparam int ACT_FRAC_W = 4;
  localparam int ACT_LUT_DEPTH = 17;
  localparam int ACT_SUM_W = ACT_DW + ACT_FRAC_W + 2;

  typedef logic signed [ACT_DW-1:0] act_t;
  typedef logic signed [ACT_DW+ACT_FRAC_W:0] act_prod_t;

  localparam act_t ACT_MAX = act_t'(2**(ACT_DW-1) - 1);
  localparam act_t ACT_MIN = act_t'(-(2**(ACT_DW-1)));

  // Indexed by z[7:4] taken unsigned: 0..7 cover z>=0,
  // 8..15 cover z<0, entry 16 closes the last segment at
  // sigmoid(0). Output scale is Q0.7 (127 ~ 1.0).
  localparam act_t ACT_SIGMOID_LUT [ACT_LUT_DEPTH] = '{
    8'sd64, 8'sd93, 8'sd112, 8'sd121,
    8'sd125, 8'sd127, 8'sd127, 8'sd127,
    8'sd0, 8'sd0, 8'sd0, 8'sd1,
    8'sd2, 8'sd6, 8'sd15, 8'sd34,
    8'sd64
  };

  function automatic act_t sat_add(
    input act_t a,
    input act_prod_t b
  );
    logic signed [ACT_SUM_W-1:0] s;
    s = ACT_SUM_W'(a) + ACT_SUM_W'(b);
    if (s > ACT_SUM_W'(ACT_MAX)) return ACT_MAX;
    if (s < ACT_SUM_W'(ACT_MIN)) return ACT_MIN;
    return act_t'(s);
  endfunction

endpackage

// File: rtl/act_rr_arbiter.sv
// act_rr_arbiter: round-robin one-hot grant over N requesters.
// Ports: clk, rst, req, advance (commit) -> grant, idx.
module act_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  localparam int CW = IW + 1;

  // ptr is the first index searched (last grant + 1)
  logic [IW-1:0] ptr;
  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    cand = '0;
    for (int o = 0; o < N; o++) begin
      cand = CW'(ptr) + CW'(o);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/act_unit_scheduler.sv
// act_unit_scheduler: shares one sigmoid LUT+interp unit among
// N_REQ requesters; round-robin, 2-stage pipe, registered rsp.
// Ports: clk, rst, req_valid/req_data/req_ready (operands),
// rsp_valid/rsp_id/rsp_data/rsp_ready (results), and with
// ACT_LUT_WRITE_EN defined cfg_we/cfg_addr/cfg_data (LUT write).
module act_unit_scheduler
  import act_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW = ACT_DW,
  parameter int ADDR_W = ACT_ADDR_W,
  parameter int FRAC_W = ACT_FRAC_W,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ACT_LUT_WRITE_EN
  input  logic              cfg_we,
  input  logic [ADDR_W:0]   cfg_addr,
  input  logic [DW-1:0]     cfg_data,
`endif
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [DW-1:0]     rsp_data,
  input  logic              rsp_ready
);

  localparam int CAW = ADDR_W + 1;

  logic             stall;
  logic             arb_en;
  logic             accept;
  logic             cfg_block;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gidx;
  logic [DW-1:0]    z;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [ADDR_W:0]   s1_addr_nx;
  logic [FRAC_W-1:0] s1_rem;
  logic [IW-1:0]     s1_id;

  act_t base_rd;
  act_t next_rd;

  logic              s2_valid;
  act_t              s2_base;
  act_t              s2_next;
  logic [FRAC_W-1:0] s2_rem;
  logic [IW-1:0]     s2_id;

  logic signed [DW:0] diff;
  act_prod_t          prod;
  act_t               act;

  // A held response freezes the whole pipe.
  assign stall = rsp_valid & ~rsp_ready;
  assign arb_en = ~rst & ~stall & ~cfg_block;

  act_rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid & {N_REQ{arb_en}}),
    .advance(accept),
    .grant(grant),
    .idx(gidx)
  );

  assign req_ready = grant;
  assign accept = |grant;
  assign z = req_data[gidx*DW +: DW];
  assign s1_addr_nx = {1'b0, s1_addr} + 1'b1;

`ifdef ACT_LUT_WRITE_EN
  act_t lut [ACT_LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      lut <= ACT_SIGMOID_LUT;
    end else if (cfg_we &&
                 cfg_addr <= CAW'(ACT_LUT_DEPTH-1)) begin
      lut[cfg_addr] <= cfg_data;
    end
  end

  // Reads register into S2 on the same edge as a write,
  // so an in-flight op sees the pre-write entry.
  assign base_rd = lut[s1_addr];
  assign next_rd = lut[s1_addr_nx];
  assign cfg_block = cfg_we;
`else
  assign base_rd = ACT_SIGMOID_LUT[s1_addr];
  assign next_rd = ACT_SIGMOID_LUT[s1_addr_nx];
  assign cfg_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr <= '0;
      s1_rem <= '0;
      s1_id <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= z[DW-1 -: ADDR_W];
        s1_rem <= z[FRAC_W-1:0];
        s1_id <= gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_base <= '0;
      s2_next <= '0;
      s2_rem <= '0;
      s2_id <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_base <= base_rd;
        s2_next <= next_rd;
        s2_rem <= s1_rem;
        s2_id <= s1_id;
      end
    end
  end

  // Interpolate: base + floor((next-base)*rem / 2^FRAC_W)
  always_comb begin
    diff = (DW+1)'(s2_next) - (DW+1)'(s2_base);
    prod = act_prod_t'(diff) *
           act_prod_t'($signed({1'b0, s2_rem}));
    act = sat_add(s2_base, prod >>> FRAC_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else if (!stall) begin
      rsp_valid <= s2_valid;
      if (s2_valid) begin
        rsp_id <= s2_id;
        rsp_data <= act;
      end
    end
  end

endmodule

// File: tb/tb_act_unit_scheduler.sv
// tb_act_unit_scheduler: directed + random stimulus against a
// queue-based reference model of the activation scheduler.
module tb_act_unit_scheduler;
  import act_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_data;
  logic         rsp_ready;
`ifdef ACT_LUT_WRITE_EN
  logic         cfg_we;
  logic [4:0]   cfg_addr;
  logic [7:0]   cfg_data;
`endif

  always #5 clk = ~clk;

  act_unit_scheduler dut (
    .clk(clk),
    .rst(rst),
`ifdef ACT_LUT_WRITE_EN
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
`endif
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  typedef struct {
    int id;
    int val;
    int age;
  } op_t;

  op_t pipe[$];
  int  tbl [17];
  int  last_g;
  int  n_cmp;
  int  n_err;
  int  seen_val;
  bit  seen;
  int  acc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic reset_tbl();
    for (int i = 0; i < 17; i++)
      tbl[i] = int'(ACT_SIGMOID_LUT[i]);
  endtask

  function automatic int ref_act(input logic [7:0] z);
    int a;
    int r;
    int b;
    int n;
    int v;
    a = int'(z[7:4]);
    r = int'(z[3:0]);
    b = tbl[a];
    n = tbl[a+1];
    v = b + (((n - b) * r) >>> 4);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // Inputs are driven at negedge; outputs sampled 1ns later.
  task automatic tick();
    int gi;
    int rid;
    int rval;
    bit stl;
    bit rv;
    bit cw;
    logic [N-1:0] eg;
    #1;
    cw = 1'b0;
`ifdef ACT_LUT_WRITE_EN
    cw = cfg_we;
`endif
    rv = 1'b0;
    rid = 0;
    rval = 0;
    foreach (pipe[i])
      if (pipe[i].age == 2) begin
        rv = 1'b1;
        rid = pipe[i].id;
        rval = pipe[i].val;
      end
    stl = rv && !rsp_ready;
    eg = '0;
    gi = -1;
    if (!rst && !stl && !cw)
      for (int o = 1; o <= N; o++) begin
        int k;
        k = (last_g + o) % N;
        if (gi < 0 && req_valid[k]) gi = k;
      end
    if (gi >= 0) eg[gi] = 1'b1;
    acc += $countones(req_ready & req_valid);
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (rv) begin
      chk("rsp_id", 32'(rsp_id), rid);
      chk("rsp_data", {{24{rsp_data[7]}}, rsp_data}, rval);
    end
    if (rsp_valid === 1'b1 && rsp_ready) begin
      seen = 1'b1;
      seen_val = int'($signed(rsp_data));
    end
    if (rst) begin
      pipe.delete();
      last_g = N - 1;
      reset_tbl();
    end else begin
`ifdef ACT_LUT_WRITE_EN
      if (cw && cfg_addr <= 5'd16)
        tbl[cfg_addr] = int'($signed(cfg_data));
`endif
      if (!stl) begin
        if (rv) void'(pipe.pop_front());
        foreach (pipe[i]) pipe[i].age++;
        if (gi >= 0) begin
          pipe.push_back('{gi, ref_act(req_data[gi*8 +: 8]), 0});
          last_g = gi;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single_op(input int lane,
                           input logic [7:0] z,
                           input int exp,
                           input string tag);
    seen = 1'b0;
    req_valid = '0;
    req_valid[lane] = 1'b1;
    req_data = 32'($urandom);
    req_data[lane*8 +: 8] = z;
    tick();
    req_valid = '0;
    for (int i = 0; i < 4 && !seen; i++) tick();
    chk(tag, seen ? 32'(seen_val) : 32'hdead, 32'(exp));
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

`ifdef ACT_LUT_WRITE_EN
  task automatic cfg_wr(input int a, input int d);
    req_valid = '0;
    cfg_we = 1'b1;
    cfg_addr = 5'(a);
    cfg_data = 8'(d);
    tick();
    cfg_we = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    acc = 0;
    seen = 1'b0;
    seen_val = 0;
    last_g = N - 1;
    pipe.delete();
    reset_tbl();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b1;
`ifdef ACT_LUT_WRITE_EN
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
`endif
    @(negedge clk);
    req_valid = '1;
    tick();
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);

    single_op(0, 8'h00, int'(ACT_SIGMOID_LUT[0]), "first_op");
    single_op(1, 8'h08, 78, "interp_pos");
    single_op(2, 8'hF8, 49, "top_seg");
    single_op(3, 8'h7F, 7, "neg_slope_floor");

    // fairness: all valid, consumer always ready
    drain();
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      req_data = 32'($urandom);
      tick();
    end

    // backpressure from an empty pipe
    drain();
    acc = 0;
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_data = 32'($urandom);
      tick();
    end
    chk("bp_accepts_le3", 32'(acc <= 3), 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      req_data = 32'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    drain();

`ifdef ACT_LUT_WRITE_EN
    cfg_wr(2, 20);
    cfg_wr(3, 36);
    single_op(0, 8'h28, 28, "lut_interp");
    single_op(1, 8'h20, 20, "lut_base");
    cfg_wr(15, 100);
    cfg_wr(16, 120);
    single_op(2, 8'hF8, 110, "lut_top");
    cfg_wr(7, 127);
    cfg_wr(8, -128);
    single_op(3, 8'h7F, -113, "sat_down");
    cfg_wr(7, -128);
    cfg_wr(8, 127);
    single_op(0, 8'h7F, 111, "sat_up");
    cfg_wr(20, 5);
    single_op(1, 8'h7F, 111, "oob_addr_ignored");
    // write lands on the edge the op reads the table
    seen = 1'b0;
    req_valid = 4'b0001;
    req_data = 32'h0000_0020;
    tick();
    req_valid = '0;
    cfg_we = 1'b1;
    cfg_addr = 5'd2;
    cfg_data = 8'd99;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("same_edge_old", seen ? 32'(seen_val) : 32'hdead, 20);
    single_op(2, 8'h20, 99, "after_write");
    drain();
`endif

    // reset with two ops in flight
    req_valid = 4'b0011;
    req_data = 32'($urandom);
    tick();
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '1;
    #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
